// File: rtl/bm_mem_arb.sv
// Single-port bitmatrix memory arbiter: round-robin between the engine read port
// and the host write port, with in-flight read tracking and a host lock handshake.
module bm_mem_arb #(
  parameter int BM_COL_W      = 64,
  parameter int BM_MEM_ADDR_W = 8,
  parameter int RD_LAT        = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     eng_rstn,
  input  logic                     bm_cntl_bm_mem_rd_rq,
  input  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
  output logic                     arb_bm_cntl_rd_gnt,
  output logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data,
  output logic                     bm_mem_bm_cntl_rd_data_val,
  input  logic                     host_bm_wr_req,
  input  logic [BM_MEM_ADDR_W-1:0] host_bm_wr_addr,
  input  logic [BM_COL_W-1:0]      host_bm_wr_data,
  output logic                     arb_host_wr_gnt,
  input  logic                     host_bm_lock,
  output logic                     arb_host_lock_ack,
  output logic                     bm_mem_cs,
  output logic                     bm_mem_we,
  output logic [BM_MEM_ADDR_W-1:0] bm_mem_addr,
  output logic [BM_COL_W-1:0]      bm_mem_wr_data,
  input  logic [BM_COL_W-1:0]      bm_mem_rd_data
);

  localparam int CNT_W = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } lock_st_t;

  lock_st_t                 r_state;
  lock_st_t                 w_state_nxt;
  logic [RD_LAT:0]          r_vld_pipe;
  logic [CNT_W-1:0]         r_inflight;
  logic [CNT_W-1:0]         w_inflight_nxt;
  logic                     r_last_wr;
  logic                     r_cs;
  logic                     r_we;
  logic [BM_MEM_ADDR_W-1:0] r_addr;
  logic [BM_COL_W-1:0]      r_wr_data;

  logic w_rd_elig;
  logic w_rd_req;
  logic w_wr_req;
  logic w_gnt_rd;
  logic w_gnt_wr;
  logic w_rd_val;

  // Grants are gated by rstn so that every output reads 0 while reset is held.
  assign w_rd_elig = rstn && eng_rstn && (r_state == ST_IDLE);
  assign w_rd_req  = bm_cntl_bm_mem_rd_rq && w_rd_elig;
  assign w_wr_req  = host_bm_wr_req && rstn;
  assign w_gnt_rd  = w_rd_req && (!w_wr_req || r_last_wr);
  assign w_gnt_wr  = w_wr_req && !w_gnt_rd;

  // A flush cycle also hides a val landing in that very cycle.
  assign w_rd_val  = r_vld_pipe[RD_LAT] && eng_rstn;

  always_comb begin
    w_inflight_nxt = r_inflight;
    if (!eng_rstn) begin
      w_inflight_nxt = '0;
    end else if (w_gnt_rd && !w_rd_val) begin
      w_inflight_nxt = r_inflight + CNT_W'(1);
    end else if (!w_gnt_rd && w_rd_val) begin
      w_inflight_nxt = r_inflight - CNT_W'(1);
    end
  end

  // Lock FSM: DRAIN exits as soon as the last outstanding val is being consumed.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (host_bm_lock) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!host_bm_lock)              w_state_nxt = ST_IDLE;
        else if (w_inflight_nxt == '0) w_state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (!host_bm_lock) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read tracking: stage k of the valid pipe lines up with cycle N+1+k after a grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_pipe <= '0;
      r_inflight <= '0;
    end else if (!eng_rstn) begin
      r_vld_pipe <= '0;
      r_inflight <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_gnt_rd};
      r_inflight <= w_inflight_nxt;
    end
  end

  // Pointer resets to "host last" so the read port wins the first contention.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_wr <= 1'b1;
    end else if (w_gnt_rd || w_gnt_wr) begin
      r_last_wr <= w_gnt_wr;
    end
  end

  // Memory command stage: grant in cycle N drives the memory in N+1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cs      <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
    end else begin
      r_cs <= w_gnt_rd || w_gnt_wr;
      r_we <= w_gnt_wr;
      if (w_gnt_wr) begin
        r_addr    <= host_bm_wr_addr;
        r_wr_data <= host_bm_wr_data;
      end else if (w_gnt_rd) begin
        r_addr    <= bm_cntl_bm_mem_rd_addr;
      end
    end
  end

  assign arb_bm_cntl_rd_gnt         = w_gnt_rd;
  assign arb_host_wr_gnt            = w_gnt_wr;
  assign arb_host_lock_ack          = (r_state == ST_LOCKED);
  assign bm_mem_bm_cntl_rd_data     = bm_mem_rd_data;
  assign bm_mem_bm_cntl_rd_data_val = w_rd_val;
  assign bm_mem_cs                  = r_cs;
  assign bm_mem_we                  = r_we;
  assign bm_mem_addr                = r_addr;
  assign bm_mem_wr_data             = r_wr_data;

endmodule

// File: tb/tb_bm_mem_arb.sv
// Scoreboard bench for bm_mem_arb: directed stimulus pushes expected memory
// commands and read data; a monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_bm_mem_arb;

  localparam int COL_W  = 64;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  data;
  } cmd_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              eng_rstn;
  logic              rd_rq;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [COL_W-1:0]  rd_data;
  logic              rd_val;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [COL_W-1:0]  wr_data;
  logic              wr_gnt;
  logic              lock;
  logic              ack;
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] maddr;
  logic [COL_W-1:0]  mwdata;
  logic [COL_W-1:0]  mrdata;

  logic [COL_W-1:0]  mem   [256];
  logic [COL_W-1:0]  rpipe [RD_LAT];

  cmd_t             cmdq[$];
  logic [COL_W-1:0] rdq[$];
  int n_cmp = 0;
  int n_err = 0;
  int wi;

  bm_mem_arb #(.BM_COL_W(COL_W), .BM_MEM_ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .eng_rstn(eng_rstn),
    .bm_cntl_bm_mem_rd_rq(rd_rq), .bm_cntl_bm_mem_rd_addr(rd_addr),
    .arb_bm_cntl_rd_gnt(rd_gnt), .bm_mem_bm_cntl_rd_data(rd_data),
    .bm_mem_bm_cntl_rd_data_val(rd_val),
    .host_bm_wr_req(wr_req), .host_bm_wr_addr(wr_addr), .host_bm_wr_data(wr_data),
    .arb_host_wr_gnt(wr_gnt), .host_bm_lock(lock), .arb_host_lock_ack(ack),
    .bm_mem_cs(cs), .bm_mem_we(we), .bm_mem_addr(maddr), .bm_mem_wr_data(mwdata),
    .bm_mem_rd_data(mrdata)
  );

  always #5 clk = ~clk;

  // Memory model: preloaded with {C0DE0000+a, 00005A00+a}, RD_LAT read latency.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= {32'hC0DE0000 + i, 32'h00005A00 + i};
    for (int i = 0; i < RD_LAT; i++) rpipe[i] <= '0;
  end

  always @(posedge clk) begin
    if (cs && we) mem[maddr] <= mwdata;
    rpipe[0] <= (cs && !we) ? mem[maddr] : '0;
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mrdata = rpipe[RD_LAT-1];

  task automatic chk(input string nm, input logic [COL_W-1:0] act, input logic [COL_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [COL_W-1:0] d);
    cmd_t c;
    c.we = w; c.addr = a; c.data = d;
    cmdq.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Monitor: every memory command and every read val must match the queues.
  always @(negedge clk) begin
    cmd_t c;
    logic [COL_W-1:0] d;
    if (cs) begin
      if (cmdq.size() == 0) begin
        chk("unexpected_cmd_addr", {63'd0, we}, 64'h2);
      end else begin
        c = cmdq.pop_front();
        chk("cmd_we", we, c.we);
        chk("cmd_addr", maddr, c.addr);
        if (c.we) chk("cmd_wdata", mwdata, c.data);
      end
    end
    if (rd_val) begin
      if (rdq.size() == 0) begin
        chk("unexpected_rd_val", rd_data, ~rd_data);
      end else begin
        d = rdq.pop_front();
        chk("rd_data", rd_data, d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; eng_rstn = 1'b1; rd_rq = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; lock = 1'b0;
    idle(2);
    @(negedge clk);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_val", rd_val, 0);
    chk("rst_cs", cs, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", maddr, 0);
    chk("rst_wdata", mwdata, 0);
    step();
    rstn = 1'b1;
    idle(2);

    // Solo read of 0x05
    rd_rq = 1'b1; rd_addr = 8'h05;
    @(negedge clk);
    chk("t1_rd_gnt", rd_gnt, 1);
    chk("t1_wr_gnt", wr_gnt, 0);
    push_cmd(1'b0, 8'h05, '0);
    rdq.push_back(64'hC0DE0005_00005A05);
    step();
    rd_rq = 1'b0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      chk("t1_val_timing", rd_val, (k == RD_LAT + 1));
      if (k == 1) chk("t1_cs", cs, 1);
      step();
    end
    idle(2);

    // Contention after reset: read, write, read, write, read, write
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    rd_rq = 1'b1; rd_addr = 8'h10;
    wr_req = 1'b1; wr_addr = 8'h20; wr_data = 64'hDEADBEEF_00000020;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t2_rd_gnt", rd_gnt, (k % 2 == 0));
      chk("t2_wr_gnt", wr_gnt, (k % 2 == 1));
      chk("t2_cs", cs, (k >= 1));
      if (k % 2 == 0) begin
        push_cmd(1'b0, 8'h10, '0);
        rdq.push_back(64'hC0DE0010_00005A10);
      end else begin
        push_cmd(1'b1, 8'h20, 64'hDEADBEEF_00000020);
      end
      step();
    end
    rd_rq = 1'b0; wr_req = 1'b0;
    idle(RD_LAT + 3);

    // Lock with two reads in flight
    rd_rq = 1'b1; rd_addr = 8'h30;
    @(negedge clk);
    chk("t3_rd0_gnt", rd_gnt, 1);
    push_cmd(1'b0, 8'h30, '0);
    rdq.push_back(64'hC0DE0030_00005A30);
    step();
    rd_addr = 8'h31; lock = 1'b1;
    @(negedge clk);
    chk("t3_rd1_gnt", rd_gnt, 1);
    push_cmd(1'b0, 8'h31, '0);
    rdq.push_back(64'hC0DE0031_00005A31);
    step();
    wi = 0;
    for (int j = 0; j <= 10; j++) begin
      rd_rq = (j <= 9); rd_addr = 8'h32;
      lock = (j <= 7);
      wr_req = 1'b1; wr_addr = 8'h40 + 8'(wi); wr_data = 64'h11110000_00000000 + 64'(wi);
      @(negedge clk);
      chk("t3_val", rd_val, (j == 1 || j == 2));
      chk("t3_ack", ack, (j >= 3 && j <= 8));
      chk("t3_rd_gnt", rd_gnt, (j == 9));
      chk("t3_wr_gnt", wr_gnt, (j != 9));
      if (j == 9) begin
        push_cmd(1'b0, 8'h32, '0);
        rdq.push_back(64'hC0DE0032_00005A32);
      end else begin
        push_cmd(1'b1, 8'h40 + 8'(wi), 64'h11110000_00000000 + 64'(wi));
        wi++;
      end
      step();
    end
    rd_rq = 1'b0; wr_req = 1'b0; lock = 1'b0;
    idle(RD_LAT + 3);

    // Engine flush discards an in-flight read; host write still granted
    rd_rq = 1'b1; rd_addr = 8'h50;
    @(negedge clk);
    chk("t4_rd_gnt", rd_gnt, 1);
    push_cmd(1'b0, 8'h50, '0);
    step();
    eng_rstn = 1'b0; rd_addr = 8'h51;
    wr_req = 1'b1; wr_addr = 8'h60; wr_data = 64'h60606060_60606060;
    @(negedge clk);
    chk("t4_flush_rd_gnt", rd_gnt, 0);
    chk("t4_flush_wr_gnt", wr_gnt, 1);
    push_cmd(1'b1, 8'h60, 64'h60606060_60606060);
    step();
    eng_rstn = 1'b1; rd_rq = 1'b0; wr_req = 1'b0;
    for (int k = 0; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      chk("t4_no_val", rd_val, 0);
      step();
    end
    lock = 1'b1;
    @(negedge clk);
    chk("t4_ack_n0", ack, 0);
    step();
    @(negedge clk);
    chk("t4_ack_n1", ack, 0);
    step();
    @(negedge clk);
    chk("t4_ack_n2", ack, 1);
    step();
    lock = 1'b0;
    idle(2);

    // Async reset in the middle of contention traffic
    rd_rq = 1'b1; rd_addr = 8'h70;
    wr_req = 1'b1; wr_addr = 8'h71; wr_data = 64'h71717171_71717171;
    @(negedge clk);
    chk("t5_rd_gnt", rd_gnt, 1);
    push_cmd(1'b0, 8'h70, '0);
    step();
    @(negedge clk);
    chk("t5_wr_gnt", wr_gnt, 1);
    step();
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_rst_rd_gnt", rd_gnt, 0);
    chk("t5_rst_wr_gnt", wr_gnt, 0);
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_val", rd_val, 0);
    chk("t5_rst_cs", cs, 0);
    chk("t5_rst_we", we, 0);
    chk("t5_rst_addr", maddr, 0);
    chk("t5_rst_wdata", mwdata, 0);
    step();
    @(negedge clk);
    chk("t5_rst_val2", rd_val, 0);
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk("t5_first_rd_gnt", rd_gnt, 1);
    chk("t5_first_wr_gnt", wr_gnt, 0);
    push_cmd(1'b0, 8'h70, '0);
    rdq.push_back(64'hC0DE0070_00005A70);
    step();
    rd_rq = 1'b0;
    @(negedge clk);
    chk("t5_then_wr_gnt", wr_gnt, 1);
    push_cmd(1'b1, 8'h71, 64'h71717171_71717171);
    step();
    wr_req = 1'b0;
    idle(RD_LAT + 3);

    // Write-only stream to addresses 0..3
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_addr = 8'(i); wr_data = 64'(i);
      @(negedge clk);
      chk("t6_wr_gnt", wr_gnt, 1);
      chk("t6_no_val", rd_val, 0);
      push_cmd(1'b1, 8'(i), 64'(i));
      step();
    end
    wr_req = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) chk("t6_mem", mem[i], 64'(i));
    rd_rq = 1'b1; rd_addr = 8'h02;
    @(negedge clk);
    chk("t6_rdback_gnt", rd_gnt, 1);
    push_cmd(1'b0, 8'h02, '0);
    rdq.push_back(64'h2);
    step();
    rd_rq = 1'b0;
    idle(RD_LAT + 3);

    chk("cmdq_drained", 64'(cmdq.size()), 0);
    chk("rdq_drained", 64'(rdq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
